irq_prio_ctrl: RTL and testbench
================================

IRQ_PRIO_CTRL -- requirements
Module: irq_prio_ctrl

Interface

Parameters:
- REQ-001: The block SHALL have parameter N_SRC, default 4, giving the number of interrupt sources (legal range 2..16).
- REQ-002: The block SHALL have parameter ID_W, default 2, giving the width of irq_id; it SHALL equal clog2(N_SRC).

Ports:
- REQ-003: clk  input  1  single clock; all logic on its rising edge. Reset is synchronous and active-high.
- REQ-004: rst  input  1  synchronous active-high reset.
- REQ-005: irq_in  input  N_SRC  raw interrupt lines; rising-edge triggered.
- REQ-006: rr_mode  input  1  0 = fixed priority, 1 = round-robin.
- REQ-007: mask_we  input  1  mask write strobe.
- REQ-008: mask_wdata  input  N_SRC  new mask value; 1 = enabled.
- REQ-009: cpu_ack  input  1  CPU accepts the presented interrupt.
- REQ-010: cpu_eoi  input  1  CPU end-of-interrupt.
- REQ-011: irq_mask  output  N_SRC  current mask register.
- REQ-012: irq_pending  output  N_SRC  latched pending bits, unmasked view.
- REQ-013: cpu_irq  output  1  interrupt request to CPU.
- REQ-014: irq_id  output  ID_W  index of the presented or active source.
- REQ-015: irq_active  output  1  a source is in service.

Function
- REQ-016: Edge detect SHALL register irq_in into prev; edge[i] = irq_in[i] & ~prev[i].
- REQ-017: An edge sampled at cycle t SHALL set irq_pending[i] at t+1 (1-cycle latency), regardless of mask.
- REQ-018: A mask write SHALL update irq_mask on the cycle after mask_we. Masked sources SHALL keep accumulating pending bits but SHALL be ineligible for selection.
- REQ-019: The eligible vector SHALL be irq_pending & irq_mask.
- REQ-020: Fixed mode SHALL select the lowest eligible index.
- REQ-021: Round-robin mode SHALL select the first eligible index at or after rr_ptr, wrapping from N_SRC-1 to 0.
- REQ-022: FSM states SHALL be IDLE, ASSERT and SERVICE; only the transitions in REQ-023..REQ-026 SHALL exist.
- REQ-023: In IDLE with eligible nonzero, the FSM SHALL latch the winner into irq_id, set cpu_irq=1 and go to ASSERT, all on the next edge.
- REQ-024: In ASSERT with cpu_ack=1, the FSM SHALL clear irq_pending[irq_id], set cpu_irq=0 and irq_active=1, and go to SERVICE. irq_id SHALL stay constant through ASSERT and SERVICE.
- REQ-025: In ASSERT, if irq_mask[irq_id]==0 and cpu_ack==0, the FSM SHALL withdraw: cpu_irq=0, go to IDLE, pending bit retained. If cpu_ack and the mask clear coincide, ack SHALL win.
- REQ-026: In SERVICE with cpu_eoi=1, the FSM SHALL set irq_active=0, set rr_ptr = (irq_id+1) mod N_SRC, and go to IDLE. Re-arbitration SHALL be earliest the following cycle, so there is at least 1 IDLE cycle between services.
- REQ-027: cpu_ack outside ASSERT and cpu_eoi outside SERVICE SHALL be ignored; no state change.
- REQ-028: If an edge on source i coincides with the clear of pending[i] by ack, set SHALL win (pending[i]=1).
- REQ-029: Edges arriving during SERVICE SHALL be latched. Multiple edges on one source before service SHALL collapse to one pending bit.
- REQ-030: The FSM SHALL be non-preemptive: a higher-priority pending source waits for EOI.
- REQ-031: rr_mode changes SHALL take effect at the next IDLE arbitration. rr_ptr SHALL be maintained in both modes.

Reset
- REQ-032: On rst=1 at a clock edge: state=IDLE, cpu_irq=0, irq_id=0, irq_active=0, irq_pending=0, irq_mask=0, rr_ptr=0, prev=all ones. Lines already high at reset release SHALL NOT create an edge.
- REQ-033: Reset asserted mid-ASSERT or mid-SERVICE SHALL abandon the interrupt with no EOI required. All pending bits SHALL be lost.

Verification
- REQ-034: Mask=4'hF, fixed mode; pulse irq_in[2] at cycle t. Required: pending=4'h4 at t+1, cpu_irq=1 and irq_id=2 at t+2. Ack then gives pending=0, irq_active=1; EOI then gives irq_active=0.
- REQ-035: Fixed mode; simultaneous edges on sources 1 and 3. Required: irq_id=1 first, then irq_id=3 after EOI and 1 IDLE cycle.
- REQ-036: rr_mode=1, mask=4'hF; all 4 sources re-pulsed after every EOI, for 8 services. Required: service order 0,1,2,3,0,1,2,3.
- REQ-037: Mask=4'h1; edge on source 2. Required: pending=4'h4, cpu_irq stays 0. Mask write 4'h5 then gives cpu_irq=1, irq_id=2 two cycles after mask_we.
- REQ-038: In ASSERT with irq_id=0, write mask=4'h0 with no ack. Required: cpu_irq=0, state IDLE, pending[0]=1. Separately, an edge on source 0 in the same cycle as its ack leaves pending[0]=1.
- REQ-039: rst pulsed during SERVICE. Required: all outputs 0 next cycle; irq_in held high through reset gives no pending.

Source files
------------

// File: rtl/irq_prio_ctrl.sv
// Edge-triggered interrupt controller: per-source pending latch, mask register,
// fixed or round-robin arbitration and a non-preemptive IDLE/ASSERT/SERVICE handshake.
module irq_prio_ctrl #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             rr_mode,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             cpu_ack,
    input  logic             cpu_eoi,
    output logic [N_SRC-1:0] irq_mask,
    output logic [N_SRC-1:0] irq_pending,
    output logic             cpu_irq,
    output logic [ID_W-1:0]  irq_id,
    output logic             irq_active
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [N_SRC-1:0] ALL_ONES = '1;

    state_e           state_q;
    logic [N_SRC-1:0] prev_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  id_q;
    logic             cpu_irq_q;
    logic             active_q;

    logic [N_SRC-1:0] edge_vec;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] id_onehot;
    logic             ack_take;

    logic [ID_W-1:0]  rr_base;
    logic [N_SRC-1:0] hi_part;
    logic [N_SRC-1:0] pick;
    logic [N_SRC-1:0] scan;
    logic [ID_W-1:0]  cnt;
    logic [ID_W-1:0]  win_id;
    logic             found;

    always_comb begin
        edge_vec  = irq_in & ~prev_q;
        eligible  = pending_q & mask_q;
        id_onehot = N_SRC'(1) << id_q;
        ack_take  = (state_q == ASSERT) && cpu_ack;
        // A new edge on the acknowledged source re-sets its bit in the same cycle.
        pending_d = (pending_q & ~(ack_take ? id_onehot : '0)) | edge_vec;
        rr_ptr_d  = (id_q == ID_W'(N_SRC - 1)) ? '0 : id_q + 1'b1;
    end

    // Round-robin: search bits at/above the pointer first, then wrap to the low part.
    always_comb begin
        rr_base = rr_mode ? rr_ptr_q : '0;
        hi_part = eligible & (ALL_ONES << rr_base);
        pick    = (hi_part != '0) ? hi_part : eligible;
        scan    = pick;
        cnt     = '0;
        win_id  = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (!found && scan[0]) begin
                found  = 1'b1;
                win_id = cnt;
            end
            scan = scan >> 1;
            cnt  = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_q    <= '1;
            pending_q <= '0;
            mask_q    <= '0;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            cpu_irq_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            prev_q    <= irq_in;
            pending_q <= pending_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
            case (state_q)
                IDLE: begin
                    if (found) begin
                        id_q      <= win_id;
                        cpu_irq_q <= 1'b1;
                        state_q   <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (cpu_ack) begin
                        cpu_irq_q <= 1'b0;
                        active_q  <= 1'b1;
                        state_q   <= SERVICE;
                    end else if ((mask_q & id_onehot) == '0) begin
                        cpu_irq_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                SERVICE: begin
                    if (cpu_eoi) begin
                        active_q <= 1'b0;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    cpu_irq_q <= 1'b0;
                    active_q  <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign irq_mask    = mask_q;
    assign irq_pending = pending_q;
    assign cpu_irq     = cpu_irq_q;
    assign irq_id      = id_q;
    assign irq_active  = active_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_irq_prio_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_in;
    logic       rr_mode;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       cpu_ack;
    logic       cpu_eoi;
    logic [3:0] irq_mask;
    logic [3:0] irq_pending;
    logic       cpu_irq;
    logic [1:0] irq_id;
    logic       irq_active;

    int checks = 0;
    int errors = 0;

    irq_prio_ctrl #(.N_SRC(4), .ID_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .rr_mode    (rr_mode),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_eoi    (cpu_eoi),
        .irq_mask   (irq_mask),
        .irq_pending(irq_pending),
        .cpu_irq    (cpu_irq),
        .irq_id     (irq_id),
        .irq_active (irq_active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
        cpu_ack = 1'b0; cpu_eoi = 1'b0; rr_mode = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we = 1'b1; mask_wdata = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] v);
        irq_in = v;
        tick();
        irq_in = '0;
    endtask

    task automatic ack_cycle();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
    endtask

    task automatic eoi_cycle();
        cpu_eoi = 1'b1;
        tick();
        cpu_eoi = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_in = '0; rr_mode = 1'b0; mask_we = 1'b0;
        mask_wdata = '0; cpu_ack = 1'b0; cpu_eoi = 1'b0;
        tick(); tick();
        checks++; if (irq_mask !== 4'h0) begin errors++; $display("FAIL reset_mask: got %h expected %h", irq_mask, 4'h0); end
        checks++; if (irq_pending !== 4'h0) begin errors++; $display("FAIL reset_pending: got %h expected %h", irq_pending, 4'h0); end
        checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL reset_cpu_irq: got %b expected 0", cpu_irq); end
        checks++; if (irq_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", irq_id); end
        checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", irq_active); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        write_mask(4'hF);
        checks++; if (irq_mask !== 4'hF) begin errors++; $display("FAIL basic_mask: got %h expected %h", irq_mask, 4'hF); end
        pulse(4'h4);
        checks++; if (irq_pending !== 4'h4) begin errors++; $display("FAIL basic_pending_t1: got %h expected %h", irq_pending, 4'h4); end
        checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL basic_irq_t1: got %b expected 0", cpu_irq); end
        tick();
        checks++; if (cpu_irq !== 1'b1) begin errors++; $display("FAIL basic_irq_t2: got %b expected 1", cpu_irq); end
        checks++; if (irq_id !== 2'd2) begin errors++; $display("FAIL basic_id_t2: got %0d expected 2", irq_id); end
        ack_cycle();
        checks++; if (irq_pending !== 4'h0) begin errors++; $display("FAIL basic_pending_ack: got %h expected %h", irq_pending, 4'h0); end
        checks++; if (irq_active !== 1'b1) begin errors++; $display("FAIL basic_active_ack: got %b expected 1", irq_active); end
        checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL basic_irq_ack: got %b expected 0", cpu_irq); end
        eoi_cycle();
        checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL basic_active_eoi: got %b expected 0", irq_active); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        write_mask(4'hF);
        pulse(4'hA);
        tick();
        checks++; if (cpu_irq !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL fixed_first: got irq=%b id=%0d expected irq=1 id=1", cpu_irq, irq_id); end
        ack_cycle();
        checks++; if (irq_pending !== 4'h8) begin errors++; $display("FAIL fixed_pending_after_ack: got %h expected %h", irq_pending, 4'h8); end
        eoi_cycle();
        checks++; if (cpu_irq !== 1'b0 || irq_active !== 1'b0) begin errors++; $display("FAIL fixed_idle_gap: got irq=%b active=%b expected 0 0", cpu_irq, irq_active); end
        tick();
        checks++; if (cpu_irq !== 1'b1 || irq_id !== 2'd3) begin errors++; $display("FAIL fixed_second: got irq=%b id=%0d expected irq=1 id=3", cpu_irq, irq_id); end
        ack_cycle();
        pulse(4'h1);
        checks++; if (irq_pending !== 4'h1) begin errors++; $display("FAIL nonpreempt_pending: got %h expected %h", irq_pending, 4'h1); end
        checks++; if (cpu_irq !== 1'b0 || irq_id !== 2'd3 || irq_active !== 1'b1) begin errors++; $display("FAIL nonpreempt_hold: got irq=%b id=%0d active=%b expected 0 3 1", cpu_irq, irq_id, irq_active); end
        eoi_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id;
        do_reset();
        write_mask(4'hF);
        rr_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_id = 2'(i % 4);
            pulse(4'hF);
            for (int w = 0; w < 4 && cpu_irq !== 1'b1; w++) tick();
            checks++; if (cpu_irq !== 1'b1) begin errors++; $display("FAIL rr_timeout[%0d]: got irq=%b expected 1", i, cpu_irq); end
            checks++; if (irq_id !== exp_id) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, irq_id, exp_id); end
            ack_cycle();
            eoi_cycle();
        end
        rr_mode = 1'b0;
    endtask

    task automatic test_mask();
        do_reset();
        write_mask(4'h1);
        pulse(4'h4);
        checks++; if (irq_pending !== 4'h4) begin errors++; $display("FAIL mask_pending: got %h expected %h", irq_pending, 4'h4); end
        tick(); tick();
        checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL mask_blocked: got %b expected 0", cpu_irq); end
        mask_we = 1'b1; mask_wdata = 4'h5;
        tick();
        mask_we = 1'b0;
        checks++; if (irq_mask !== 4'h5 || cpu_irq !== 1'b0) begin errors++; $display("FAIL mask_write_t1: got mask=%h irq=%b expected 5 0", irq_mask, cpu_irq); end
        tick();
        checks++; if (cpu_irq !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL mask_write_t2: got irq=%b id=%0d expected 1 2", cpu_irq, irq_id); end
        ack_cycle();
        eoi_cycle();
        pulse(4'h1);
        tick();
        checks++; if (cpu_irq !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL withdraw_setup: got irq=%b id=%0d expected 1 0", cpu_irq, irq_id); end
        write_mask(4'h0);
        checks++; if (cpu_irq !== 1'b1) begin errors++; $display("FAIL withdraw_early: got %b expected 1", cpu_irq); end
        tick();
        checks++; if (cpu_irq !== 1'b0 || irq_pending !== 4'h1 || irq_active !== 1'b0) begin errors++; $display("FAIL withdraw: got irq=%b pend=%h active=%b expected 0 1 0", cpu_irq, irq_pending, irq_active); end
        tick();
        checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL withdraw_idle: got %b expected 0", cpu_irq); end
    endtask

    task automatic test_ack_collision();
        do_reset();
        write_mask(4'hF);
        pulse(4'h1);
        tick();
        cpu_ack = 1'b1; irq_in = 4'h1;
        tick();
        cpu_ack = 1'b0; irq_in = 4'h0;
        checks++; if (irq_pending !== 4'h1 || irq_active !== 1'b1) begin errors++; $display("FAIL ack_edge_collision: got pend=%h active=%b expected 1 1", irq_pending, irq_active); end
        eoi_cycle();
        tick();
        checks++; if (cpu_irq !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL ack_mask_setup: got irq=%b id=%0d expected 1 0", cpu_irq, irq_id); end
        write_mask(4'h0);
        ack_cycle();
        checks++; if (irq_active !== 1'b1 || cpu_irq !== 1'b0 || irq_pending !== 4'h0) begin errors++; $display("FAIL ack_beats_mask: got active=%b irq=%b pend=%h expected 1 0 0", irq_active, cpu_irq, irq_pending); end
        eoi_cycle();
        cpu_ack = 1'b1; cpu_eoi = 1'b1;
        tick();
        cpu_ack = 1'b0; cpu_eoi = 1'b0;
        checks++; if (cpu_irq !== 1'b0 || irq_active !== 1'b0) begin errors++; $display("FAIL stray_ack_eoi: got irq=%b active=%b expected 0 0", cpu_irq, irq_active); end
    endtask

    task automatic test_reset_in_service();
        do_reset();
        write_mask(4'hF);
        pulse(4'h2);
        tick();
        ack_cycle();
        checks++; if (irq_active !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL rst_svc_setup: got active=%b id=%0d expected 1 1", irq_active, irq_id); end
        irq_in = 4'hF; rst = 1'b1;
        tick();
        checks++; if ({irq_mask, irq_pending, cpu_irq, irq_id, irq_active} !== 13'd0) begin errors++; $display("FAIL rst_svc_outputs: got mask=%h pend=%h irq=%b id=%0d active=%b expected all 0", irq_mask, irq_pending, cpu_irq, irq_id, irq_active); end
        rst = 1'b0;
        tick(); tick();
        checks++; if (irq_pending !== 4'h0) begin errors++; $display("FAIL rst_held_lines: got %h expected %h", irq_pending, 4'h0); end
        write_mask(4'hF);
        tick();
        checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL rst_no_irq: got %b expected 0", cpu_irq); end
        irq_in = 4'h0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fixed_priority();
        test_round_robin();
        test_mask();
        test_ack_collision();
        test_reset_in_service();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
